// File: rtl/clb_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : clb_cfg_loader
// Description : Serial configuration loader for the CLB array. It hunts for
//               a sync byte, then takes one CFG_W-bit word plus an even-parity
//               bit for each CLB in turn. Every good word is written to its
//               CLB through the shared config bus and a one-hot write enable.
// Revision    : 1.0 - initial release
// ============================================================================
module clb_cfg_loader #(
    parameter int           N_CLB    = 16,
    parameter int           CFG_W    = 23,
    parameter logic [7:0]   SYNC_PAT = 8'hA5,
    localparam int          IDX_W    = (N_CLB > 1) ? $clog2(N_CLB) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ser_valid,
    input  logic             ser_data,
    output logic             ser_ready,
    output logic [CFG_W-1:0] clb_bits,
    output logic [N_CLB-1:0] clb_wr_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IDX_W-1:0] err_idx
);

    localparam int BC_W = $clog2(CFG_W + 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SYNC  = 3'd1;
    localparam logic [2:0] c_WORD  = 3'd2;
    localparam logic [2:0] c_PAR   = 3'd3;
    localparam logic [2:0] c_WRITE = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;
    localparam logic [2:0] c_ERR   = 3'd6;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_CLB - 1);
    localparam logic [BC_W-1:0]  c_LAST_BIT = BC_W'(CFG_W - 1);

    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_err_idx;
    logic [BC_W-1:0]  r_bitcnt;
    logic [7:0]       r_window;
    logic [CFG_W-1:0] r_shift;

    logic             w_accept;
    logic [7:0]       w_window_nxt;

    // A bit is consumed only when the host offers one and we are listening.
    assign w_accept     = ser_valid && ser_ready;
    assign w_window_nxt = {r_window[6:0], ser_data};

    // Status and bus outputs are pure decodes of registered state.
    assign ser_ready = (r_state == c_SYNC) || (r_state == c_WORD) || (r_state == c_PAR);
    assign busy      = ser_ready || (r_state == c_WRITE);
    assign done      = (r_state == c_DONE);
    assign err       = (r_state == c_ERR);
    assign err_idx   = r_err_idx;
    assign clb_bits  = r_shift;
    assign clb_wr_en = (r_state == c_WRITE) ? (N_CLB'(1) << r_idx) : '0;

    // Frame sequencer: sync hunt, word/parity capture, per-CLB write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_idx     <= '0;
            r_err_idx <= '0;
            r_bitcnt  <= '0;
            r_window  <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE, c_ERR: begin
                    if (start) begin
                        r_state  <= c_SYNC;
                        r_idx    <= '0;
                        r_bitcnt <= '0;
                        r_window <= '0;
                    end
                end
                c_SYNC: begin
                    if (w_accept) begin
                        r_window <= w_window_nxt;
                        // Match includes the bit arriving this cycle.
                        if (w_window_nxt == SYNC_PAT) begin
                            r_state  <= c_WORD;
                            r_bitcnt <= '0;
                        end
                    end
                end
                c_WORD: begin
                    if (w_accept) begin
                        r_shift <= {r_shift[CFG_W-2:0], ser_data};
                        if (r_bitcnt == c_LAST_BIT) begin
                            r_bitcnt <= '0;
                            r_state  <= c_PAR;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end
                end
                c_PAR: begin
                    if (w_accept) begin
                        // Even parity over word plus parity bit.
                        if ((^r_shift) ^ ser_data) begin
                            r_state   <= c_ERR;
                            r_err_idx <= r_idx;
                        end else begin
                            r_state <= c_WRITE;
                        end
                    end
                end
                c_WRITE: begin
                    // Words follow back to back with no further sync byte.
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= c_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= c_WORD;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clb_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_clb_cfg_loader
// Description : Directed self-checking bench for clb_cfg_loader with N_CLB=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clb_cfg_loader;

    localparam int N_CLB = 2;
    localparam int CFG_W = 23;

    logic             clk;
    logic             rst;
    logic             start;
    logic             ser_valid;
    logic             ser_data;
    logic             ser_ready;
    logic [CFG_W-1:0] clb_bits;
    logic [N_CLB-1:0] clb_wr_en;
    logic             busy;
    logic             done;
    logic             err;
    logic [0:0]       err_idx;

    int n_tests = 0;
    int n_fail  = 0;
    int n_multi = 0;

    logic [N_CLB-1:0] log_en[$];
    logic [CFG_W-1:0] log_bits[$];

    clb_cfg_loader #(
        .N_CLB    (N_CLB),
        .CFG_W    (CFG_W),
        .SYNC_PAT (8'hA5)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_ready (ser_ready),
        .clb_bits  (clb_bits),
        .clb_wr_en (clb_wr_en),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_idx   (err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every cycle that has a write enable asserted, mid-cycle.
    always @(negedge clk) begin
        if (clb_wr_en != '0) begin
            log_en.push_back(clb_wr_en);
            log_bits.push_back(clb_bits);
            if ($countones(clb_wr_en) != 1) n_multi++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        int k;
        k = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        ser_valid = 1'b1;
        ser_data  = b;
        while (!ser_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!ser_ready) chk("ready_timeout", 32'(ser_ready), 32'd1);
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
    endtask

    task automatic send_word(input logic [CFG_W-1:0] w, input logic p, input int gap);
        for (int i = CFG_W - 1; i >= 0; i--) send_bit(w[i], gap);
        send_bit(p, gap);
    endtask

    task automatic send_frame(input int gap);
        send_byte(8'hA5, gap);
        send_word(23'h7FFFFF, 1'b1, gap);
        send_word(23'h000000, 1'b0, gap);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait past the final WRITE so the done flag and log are settled.
    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_en.delete();
        log_bits.delete();
    endtask

    task automatic check_good_load(input string tag);
        logic [N_CLB-1:0] e0, e1;
        logic [CFG_W-1:0] b0, b1;
        e0 = (log_en.size()   > 0) ? log_en[0]   : '0;
        b0 = (log_bits.size() > 0) ? log_bits[0] : 23'h5A5A5A;
        e1 = (log_en.size()   > 1) ? log_en[1]   : '0;
        b1 = (log_bits.size() > 1) ? log_bits[1] : 23'h5A5A5A;
        chk({tag, "_nwr"},   32'(log_en.size()), 32'd2);
        chk({tag, "_en0"},   32'(e0), 32'h1);
        chk({tag, "_bits0"}, 32'(b0), 32'h7FFFFF);
        chk({tag, "_en1"},   32'(e1), 32'h2);
        chk({tag, "_bits1"}, 32'(b1), 32'h000000);
        chk({tag, "_done"},  32'(done), 32'd1);
        chk({tag, "_err"},   32'(err),  32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_err",   32'(err),       32'd0);
        chk("rst_ready", 32'(ser_ready), 32'd0);
        chk("rst_wren",  32'(clb_wr_en), 32'd0);
        chk("rst_bits",  32'(clb_bits),  32'd0);

        // 1: basic two-word load
        clear_log();
        do_start();
        #1;
        chk("t1_busy",  32'(busy),      32'd1);
        chk("t1_ready", 32'(ser_ready), 32'd1);
        send_frame(0);
        settle();
        check_good_load("t1");

        // 2: leading garbage before the sync byte
        clear_log();
        do_start();
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_byte(8'hA5, 0);
        chk("t2_no_early_wr", 32'(log_en.size()), 32'd0);
        send_word(23'h7FFFFF, 1'b1, 0);
        send_word(23'h000000, 1'b0, 0);
        settle();
        check_good_load("t2");

        // 3: parity failure on the second word
        clear_log();
        do_start();
        send_byte(8'hA5, 0);
        send_word(23'h7FFFFF, 1'b1, 0);
        send_word(23'h000001, 1'b0, 0);
        settle();
        chk("t3_nwr",    32'(log_en.size()), 32'd1);
        chk("t3_en0",    32'((log_en.size() > 0) ? log_en[0] : 2'b00), 32'h1);
        chk("t3_err",    32'(err),     32'd1);
        chk("t3_erridx", 32'(err_idx), 32'd1);
        chk("t3_busy",   32'(busy),    32'd0);
        chk("t3_done",   32'(done),    32'd0);
        chk("t3_ready",  32'(ser_ready), 32'd0);

        // 4: sparse ser_valid, one bit every third cycle
        clear_log();
        do_start();
        chk("t4_err_clr", 32'(err), 32'd0);
        send_frame(2);
        settle();
        check_good_load("t4");

        // 5: asynchronous reset in the middle of CLB 1's word
        clear_log();
        do_start();
        send_byte(8'hA5, 0);
        send_word(23'h7FFFFF, 1'b1, 0);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_busy",  32'(busy),      32'd0);
        chk("t5_ready", 32'(ser_ready), 32'd0);
        chk("t5_wren",  32'(clb_wr_en), 32'd0);
        chk("t5_bits",  32'(clb_bits),  32'd0);
        chk("t5_done",  32'(done),      32'd0);
        chk("t5_err",   32'(err),       32'd0);
        chk("t5_nwr",   32'(log_en.size()), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        do_start();
        send_frame(0);
        settle();
        check_good_load("t5");

        // 6: start during WORD is ignored; start in DONE restarts cleanly
        clear_log();
        do_start();
        send_byte(8'hA5, 0);
        send_word(23'h7FFFFF, 1'b1, 0);
        for (int i = 22; i >= 18; i--) send_bit(1'b0, 0);
        do_start();
        for (int i = 17; i >= 0; i--) send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        settle();
        check_good_load("t6a");
        clear_log();
        do_start();
        #1;
        chk("t6_done_clr", 32'(done), 32'd0);
        chk("t6_busy",     32'(busy), 32'd1);
        send_frame(0);
        settle();
        check_good_load("t6b");

        chk("onehot", 32'(n_multi), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
